// File: rtl/ldtu_hamm_tx_encoder.sv
// Hamming SEC encoder (32 -> 38 bits) feeding a 2-entry output FIFO, with an encoded-word counter.
// Optional one-shot codeword bit-flip injection when HAMM_TX_ERR_INJ_EN is defined.
module ldtu_hamm_tx_encoder #(
  parameter int Nbits_32  = 32,
  parameter int Nbits_ham = 38,
  parameter int CNT_W     = 16
)(
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [Nbits_32-1:0]  data_input,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [Nbits_ham-1:0] data_ham_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     word_count,
  input  logic [5:0]           err_inj_pos,
  input  logic                 err_inj_req
);

  logic [Nbits_ham-1:0] dw, cw, wr_word;
  logic [5:0]           par;
  logic [Nbits_ham-1:0] mem_q [2];
  logic [Nbits_ham-1:0] last_q;
  logic                 head_q, tail_q;
  logic [1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]     wc_q, wc_d;
  logic                 accept, pop;

  // Data bits fill the non-power-of-two positions; layout mirrors the receive decoder.
  always_comb begin
    dw        = '0;
    dw[2]     = data_input[0];
    dw[6:4]   = data_input[3:1];
    dw[14:8]  = data_input[10:4];
    dw[30:16] = data_input[25:11];
    dw[37:32] = data_input[31:26];
    cw        = dw;
    par       = '0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < Nbits_ham; i++)
        if ((((i + 1) >> k) % 2) == 1) par[k] = par[k] ^ dw[i];
      cw[(1 << k) - 1] = par[k];
    end
  end

  assign out_valid  = (cnt_q != 2'd0);
  assign in_ready   = ~reset & (cnt_q != 2'd2);
  assign accept     = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign data_ham_in = out_valid ? mem_q[head_q] : last_q;
  assign word_count = wc_q;
  assign wc_d       = wc_q + CNT_W'(1);

  always_comb begin
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef HAMM_TX_ERR_INJ_EN
  logic       arm_q, arm_d, eff_arm;
  logic [5:0] pos_q, pos_d, eff_pos;

  // A request in the same cycle as an accept targets that very word.
  always_comb begin
    eff_arm = arm_q | err_inj_req;
    eff_pos = err_inj_req ? err_inj_pos : pos_q;
    wr_word = cw;
    if (eff_arm && (eff_pos < 6'd38)) wr_word[eff_pos] = ~cw[eff_pos];
    arm_d   = accept ? 1'b0 : eff_arm;
    pos_d   = eff_pos;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      arm_q <= 1'b0;
      pos_q <= '0;
    end else begin
      arm_q <= arm_d;
      pos_q <= pos_d;
    end
  end
`else
  logic unused_inj;
  assign unused_inj = ^{err_inj_pos, err_inj_req};
  assign wr_word    = cw;
`endif

  // last_q keeps the most recently popped word visible while the FIFO is empty.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      last_q   <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      cnt_q    <= 2'd0;
      wc_q     <= '0;
    end else begin
      if (accept) begin
        mem_q[tail_q] <= wr_word;
        tail_q        <= ~tail_q;
        wc_q          <= wc_d;
      end
      if (pop) begin
        last_q <= mem_q[head_q];
        head_q <= ~head_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ldtu_hamm_tx_encoder.sv
// Bench for ldtu_hamm_tx_encoder: generic Hamming model + FIFO queue model checked every cycle,
// plus directed vectors with literal expectations. Injection cases run when HAMM_TX_ERR_INJ_EN is defined.
module tb_ldtu_hamm_tx_encoder;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] data_input;
  logic        in_valid, out_ready;
  logic [5:0]  err_inj_pos;
  logic        err_inj_req;
  logic        in_ready, out_valid;
  logic [37:0] data_ham_in;
  logic [15:0] word_count;
  logic        in_ready4, out_valid4;
  logic [37:0] data_ham_in4;
  logic [3:0]  word_count4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [37:0] cw;
    logic [31:0] data;
    logic        inj;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  logic [37:0] last_cw = '0;
  int          mcnt = 0;
  logic        m_arm = 1'b0;
  logic [5:0]  m_pos = '0;
  logic        m_acc, m_pop, m_eff_arm;
  logic [5:0]  m_eff_pos;
  logic [37:0] popped[$];
  logic [31:0] dd;
  logic        de;

  always #5 CLK = ~CLK;

  ldtu_hamm_tx_encoder #(.CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .data_input(data_input), .in_valid(in_valid),
    .in_ready(in_ready), .data_ham_in(data_ham_in), .out_valid(out_valid),
    .out_ready(out_ready), .word_count(word_count),
    .err_inj_pos(err_inj_pos), .err_inj_req(err_inj_req)
  );

  ldtu_hamm_tx_encoder #(.CNT_W(4)) dut4 (
    .CLK(CLK), .reset(reset), .data_input(data_input), .in_valid(in_valid),
    .in_ready(in_ready4), .data_ham_in(data_ham_in4), .out_valid(out_valid4),
    .out_ready(out_ready), .word_count(word_count4),
    .err_inj_pos(err_inj_pos), .err_inj_req(err_inj_req)
  );

  function automatic logic is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Textbook Hamming: data bits in ascending non-power-of-two positions, parity over covered positions.
  function automatic logic [37:0] enc(input logic [31:0] d);
    logic [37:0] c;
    logic        x;
    int          j;
    c = '0;
    j = 0;
    for (int p = 1; p <= 38; p++)
      if (!is_pow2(p)) begin
        c[p-1] = d[j];
        j++;
      end
    for (int k = 0; k < 6; k++) begin
      x = 1'b0;
      for (int p = 1; p <= 38; p++)
        if (((p >> k) & 1) == 1 && !is_pow2(p)) x = x ^ c[p-1];
      c[(1 << k) - 1] = x;
    end
    return c;
  endfunction

  task automatic decode(input logic [37:0] c_in, output logic [31:0] d, output logic err);
    logic [37:0] c;
    int          syn;
    int          j;
    c   = c_in;
    syn = 0;
    for (int p = 1; p <= 38; p++)
      if (c[p-1]) syn = syn ^ p;
    err = (syn != 0);
    if (syn >= 1 && syn <= 38) c[syn-1] = ~c[syn-1];
    j = 0;
    d = '0;
    for (int p = 1; p <= 38; p++)
      if (!is_pow2(p)) begin
        d[j] = c[p-1];
        j++;
      end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: plain queue of accepted codewords.
  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      q.delete();
      last_cw = '0;
      mcnt    = 0;
      m_arm   = 1'b0;
      m_pos   = '0;
    end else begin
      m_acc     = in_valid && (q.size() < 2);
      m_pop     = (q.size() > 0) && out_ready;
      m_eff_arm = m_arm || err_inj_req;
      m_eff_pos = err_inj_req ? err_inj_pos : m_pos;
      if (m_pop) begin
        last_cw = q[0].cw;
        void'(q.pop_front());
      end
      if (m_acc) begin
        e.data = data_input;
        e.cw   = enc(data_input);
        e.inj  = 1'b0;
`ifdef HAMM_TX_ERR_INJ_EN
        if (m_eff_arm && m_eff_pos < 6'd38) begin
          e.cw[m_eff_pos] = ~e.cw[m_eff_pos];
          e.inj = 1'b1;
        end
`endif
        q.push_back(e);
        mcnt++;
      end
`ifdef HAMM_TX_ERR_INJ_EN
      m_arm = m_acc ? 1'b0 : m_eff_arm;
      m_pos = m_eff_pos;
`endif
    end
  end

  always @(negedge CLK) begin
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(!reset && q.size() < 2));
    chk("data_ham_in", 64'(data_ham_in), 64'((q.size() > 0) ? q[0].cw : last_cw));
    chk("word_count", 64'(word_count), 64'(mcnt % 65536));
    chk("word_count4", 64'(word_count4), 64'(mcnt % 16));
    if (out_valid && out_ready && q.size() > 0) begin
      decode(data_ham_in, dd, de);
      chk("decoded_data", 64'(dd), 64'(q[0].data));
      chk("decoded_err", 64'(de), 64'(q[0].inj));
      popped.push_back(data_ham_in);
    end
  end

  initial begin : stim
    logic [31:0] d0;
    logic        e0;
    int          m0;
    reset = 1'b1; data_input = '0; in_valid = 1'b0; out_ready = 1'b0;
    err_inj_pos = '0; err_inj_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(data_ham_in), 64'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_release", 64'(in_ready), 64'd1);

    // Pin the model with hand-computed codewords.
    chk("model_enc_1", 64'(enc(32'h00000001)), 64'h0000000007);
    chk("model_enc_ff", 64'(enc(32'hFFFFFFFF)), 64'h3F7FFFFFF4);
    chk("model_enc_msb", 64'(enc(32'h80000000)), 64'h208000000A);
    decode(38'h0000000027, d0, e0);
    chk("model_dec_data", 64'(d0), 64'h1);
    chk("model_dec_err", 64'(e0), 64'h1);

    // Directed encodes, downstream always ready.
    out_ready = 1'b1;
    in_valid = 1'b1; data_input = 32'h00000001; step(); in_valid = 1'b0;
    chk("enc_1", 64'(data_ham_in), 64'h0000000007);
    chk("enc_1_valid", 64'(out_valid), 64'd1);
    step();
    in_valid = 1'b1; data_input = 32'hFFFFFFFF; step(); in_valid = 1'b0;
    chk("enc_ff", 64'(data_ham_in), 64'h3F7FFFFFF4);
    step();
    in_valid = 1'b1; data_input = 32'h80000000; step(); in_valid = 1'b0;
    chk("enc_msb", 64'(data_ham_in), 64'h208000000A);
    step();
    chk("empty_holds_last", 64'(data_ham_in), 64'h208000000A);

    // Back-pressure: A, B fill the FIFO, C is held off.
    popped.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; data_input = 32'h00000001; step();
    data_input = 32'h80000000; step();
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    data_input = 32'hFFFFFFFF; step();
    chk("bp_held_ready", 64'(in_ready), 64'd0);
    chk("bp_head_stable", 64'(data_ham_in), 64'h0000000007);
    chk("bp_count", 64'(word_count), 64'd5);
    out_ready = 1'b1; step();
    step();
    in_valid = 1'b0; step();
    step();
    chk("bp_pop_count", 64'(popped.size()), 64'd3);
    if (popped.size() == 3) begin
      chk("bp_order_A", 64'(popped[0]), 64'h0000000007);
      chk("bp_order_B", 64'(popped[1]), 64'h208000000A);
      chk("bp_order_C", 64'(popped[2]), 64'h3F7FFFFFF4);
    end

    // Asynchronous reset with two words queued.
    out_ready = 1'b0;
    in_valid = 1'b1; data_input = 32'h00001234; step();
    data_input = 32'h00005678; step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_data", 64'(data_ham_in), 64'd0);
    chk("arst_count", 64'(word_count), 64'd0);
    step();
    reset = 1'b0;
    #1;
    chk("arst_release_ready", 64'(in_ready), 64'd1);

    // Streaming 1000 random words at full rate.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    m0 = mcnt;
    for (int i = 0; i < 1000; i++) begin
      data_input = $urandom;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("stream_throughput", 64'(mcnt - m0), 64'd1000);
    chk("stream_count", 64'(word_count), 64'd1000);
    chk("stream_count4", 64'(word_count4), 64'd8);

    // Narrow counter wrap: 17 accepts.
    reset = 1'b1; step(); reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_input = 32'(i * 7 + 3);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("wrap_count4", 64'(word_count4), 64'd1);
    chk("wrap_count16", 64'(word_count), 64'd17);

`ifdef HAMM_TX_ERR_INJ_EN
    err_inj_pos = 6'd5; err_inj_req = 1'b1;
    in_valid = 1'b1; data_input = 32'h00000001; step();
    err_inj_req = 1'b0; in_valid = 1'b0;
    chk("inj_word", 64'(data_ham_in), 64'h0000000027);
    decode(data_ham_in, d0, e0);
    chk("inj_dec_data", 64'(d0), 64'h1);
    chk("inj_dec_err", 64'(e0), 64'h1);
    step();
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("inj_next_clean", 64'(data_ham_in), 64'h0000000007);
    step();
    err_inj_pos = 6'd40; err_inj_req = 1'b1; step(); err_inj_req = 1'b0;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    chk("inj_out_of_range", 64'(data_ham_in), 64'h0000000007);
    step();
`endif

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
